emif_bus_frontend: RTL

- Upstream stage of the EMIF register-file slave.
- Converts the DSP's asynchronous EMIF strobes (nCS, nWE, nOE) into clean single-cycle request pulses in the PLL clock domain.
- Latches address, byte enables and write data, and manages the read-data return (tri-state enable, EMIF_nWAIT).
- The register file behind it sees a simple synchronous interface: request pulse in, read data with valid flag back.

---
 rtl/emif_bus_frontend.sv | 312 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/emif_bus_frontend.sv
// ---------------------------------------------------------------------------
// emif_bus_frontend
//
// Upstream stage of the EMIF register-file slave. Turns the DSP's
// asynchronous EMIF strobes (nCS / nWE / nOE) into single-cycle request
// pulses in the c0 (PLL) clock domain. It latches address, byte enables and
// write data, and manages read-data return to the pad (driver enable and
// EMIF_nWAIT). The register file behind it sees a plain synchronous
// interface: a request pulse in, read data with a valid flag back.
//
// Optional feature (compile-time macro EMIF_RD_TIMEOUT_EN):
//   When defined, a read that gets no reg_rvalid within RD_TIMEOUT cycles
//   returns RD_ERR_WORD to the DSP. When undefined, a read waits for
//   reg_rvalid indefinitely and the timeout counter does not exist.
//
// Parameters:
//   ADDR_W       word-address width, reg_addr = {EMIF_A, EMIF_BA[1]}
//   DATA_W       EMIF data width
//   SYNC_STAGES  synchroniser depth on nCS/nWE/nOE (>= 2)
//   SETTLE       cycles waited after a write-strobe fall before sampling
//                the pins (>= 1)
//   RD_TIMEOUT   read timeout in cycles (EMIF_RD_TIMEOUT_EN only)
//   RD_ERR_WORD  data returned on read timeout (EMIF_RD_TIMEOUT_EN only)
//
// Ports:
//   c0          in   PLL system clock, rising edge
//   nRST        in   synchronous active-low reset
//   EMIF_nCS    in   async chip select, active-low
//   EMIF_nWE    in   async write enable, active-low
//   EMIF_nOE    in   async output enable, active-low
//   EMIF_nDQM   in   async byte enables, active-low
//   EMIF_A      in   async word address
//   EMIF_BA     in   async bank address; BA[1] is the address LSB
//   EMIF_D_in   in   data from the pad
//   EMIF_D_out  out  data to the pad
//   EMIF_D_oe   out  pad driver enable (high only while driving read data)
//   EMIF_nWAIT  out  active-low wait to the DSP
//   reg_addr    out  latched word address
//   reg_wdata   out  latched write data
//   reg_be      out  latched byte enables, active-high
//   reg_wr      out  single-cycle write request
//   reg_rd      out  single-cycle read request
//   reg_rdata   in   read data from the register file
//   reg_rvalid  in   reg_rdata valid (same cycle as reg_rd or later)
//   proto_err   out  sticky: nWE and nOE seen low together; reset clears it
// ---------------------------------------------------------------------------
module emif_bus_frontend #(
    parameter int ADDR_W      = 23,
    parameter int DATA_W      = 16,
    parameter int SYNC_STAGES = 2,
    parameter int SETTLE      = 2
`ifdef EMIF_RD_TIMEOUT_EN
    ,
    parameter int                RD_TIMEOUT  = 64,
    parameter logic [DATA_W-1:0] RD_ERR_WORD = 16'hBAD0
`endif
) (
    input  logic              c0,
    input  logic              nRST,
    input  logic              EMIF_nCS,
    input  logic              EMIF_nWE,
    input  logic              EMIF_nOE,
    input  logic [1:0]        EMIF_nDQM,
    input  logic [21:0]       EMIF_A,
    input  logic [1:0]        EMIF_BA,
    input  logic [DATA_W-1:0] EMIF_D_in,
    output logic [DATA_W-1:0] EMIF_D_out,
    output logic              EMIF_D_oe,
    output logic              EMIF_nWAIT,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [DATA_W-1:0] reg_wdata,
    output logic [1:0]        reg_be,
    output logic              reg_wr,
    output logic              reg_rd,
    input  logic [DATA_W-1:0] reg_rdata,
    input  logic              reg_rvalid,
    output logic              proto_err
);

    typedef enum logic [2:0] {
        IDLE,
        WR_SETTLE,
        WR_HOLD,
        RD_REQ,
        RD_WAIT,
        RD_DRIVE,
        WAIT_IDLE
    } state_t;

    // One counter serves both the write settle delay and (optionally) the
    // read timeout; it is sized for whichever needs more range.
`ifdef EMIF_RD_TIMEOUT_EN
    localparam int CNT_MAX = (SETTLE > RD_TIMEOUT) ? SETTLE : RD_TIMEOUT;
`else
    localparam int CNT_MAX = SETTLE;
`endif
    localparam int CNT_W = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
`ifdef EMIF_RD_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(RD_TIMEOUT - 1);
`endif

    // ------------------------------------------------------------------
    // Strobe synchronisers and edge detection
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] we_sync;
    logic [SYNC_STAGES-1:0] oe_sync;
    logic                   we_prev;
    logic                   oe_prev;

    logic cs_s;
    logic we_s;
    logic oe_s;
    logic we_fall;
    logic oe_fall;

    assign cs_s    = cs_sync[SYNC_STAGES-1];
    assign we_s    = we_sync[SYNC_STAGES-1];
    assign oe_s    = oe_sync[SYNC_STAGES-1];
    assign we_fall = we_prev & ~we_s;
    assign oe_fall = oe_prev & ~oe_s;

    // Address, data and byte enables are taken straight from the pins: the
    // EMIF timing keeps them stable for the whole time the strobe is low,
    // which covers the synchroniser and settle latency.
    logic [ADDR_W-1:0] pin_addr;
    assign pin_addr = ADDR_W'({EMIF_A, EMIF_BA[1]});

    // BA[0] carries no information for a 16-bit word-addressed slave.
    logic unused_ba0;
    assign unused_ba0 = EMIF_BA[0];

    // ------------------------------------------------------------------
    // FSM: next-state / next-output logic
    // ------------------------------------------------------------------
    state_t            state;
    state_t            state_d;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_d;
    logic              reg_wr_d;
    logic              reg_rd_d;
    logic [ADDR_W-1:0] reg_addr_d;
    logic [DATA_W-1:0] reg_wdata_d;
    logic [1:0]        reg_be_d;
    logic [DATA_W-1:0] d_out_d;
    logic              d_oe_d;
    logic              nwait_d;
    logic              proto_err_d;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case statement can leave one unassigned and infer a latch.
        state_d     = state;
        cnt_d       = cnt;
        reg_wr_d    = 1'b0;
        reg_rd_d    = 1'b0;
        reg_addr_d  = reg_addr;
        reg_wdata_d = reg_wdata;
        reg_be_d    = reg_be;
        d_out_d     = EMIF_D_out;
        d_oe_d      = 1'b0;  // only RD_DRIVE (or entry into it) raises this
        nwait_d     = 1'b1;  // only the read-wait path pulls this low
        // Both strobes low is illegal whatever the FSM is doing.
        proto_err_d = proto_err | (~we_s & ~oe_s);

        case (state)
            IDLE: begin
                if (!cs_s) begin
                    if (we_fall && oe_fall) begin
                        // Ambiguous access: issue nothing, wait for release.
                        state_d = WAIT_IDLE;
                    end else if (we_fall) begin
                        cnt_d   = '0;
                        state_d = WR_SETTLE;
                    end else if (oe_fall) begin
                        // Latch on entry so reg_addr/reg_be are valid while
                        // reg_rd is high during RD_REQ.
                        reg_addr_d = pin_addr;
                        reg_be_d   = ~EMIF_nDQM;
                        reg_rd_d   = 1'b1;
                        state_d    = RD_REQ;
                    end
                end
            end

            WR_SETTLE: begin
                if (cnt == SETTLE_LAST) begin
                    reg_addr_d  = pin_addr;
                    reg_wdata_d = EMIF_D_in;
                    reg_be_d    = ~EMIF_nDQM;
                    reg_wr_d    = 1'b1;
                    state_d     = WR_HOLD;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end

            WR_HOLD: begin
                // One reg_wr per strobe, however long the strobe stays low.
                if (we_s || cs_s) begin
                    state_d = IDLE;
                end
            end

            RD_REQ: begin
                if (oe_s || cs_s) begin
                    state_d = IDLE;
                end else if (reg_rvalid) begin
                    // Zero-latency register file: skip the wait state.
                    d_out_d = reg_rdata;
                    d_oe_d  = 1'b1;
                    state_d = RD_DRIVE;
                end else begin
                    nwait_d = 1'b0;
                    cnt_d   = '0;
                    state_d = RD_WAIT;
                end
            end

            RD_WAIT: begin
                // A strobe release aborts the read; a reg_rvalid arriving
                // afterwards is simply never looked at.
                if (oe_s || cs_s) begin
                    state_d = IDLE;
                end else if (reg_rvalid) begin
                    d_out_d = reg_rdata;
                    d_oe_d  = 1'b1;
                    state_d = RD_DRIVE;
`ifdef EMIF_RD_TIMEOUT_EN
                end else if (cnt == TIMEOUT_LAST) begin
                    d_out_d = RD_ERR_WORD;
                    d_oe_d  = 1'b1;
                    state_d = RD_DRIVE;
                end else begin
                    nwait_d = 1'b0;
                    cnt_d   = cnt + 1'b1;
                end
`else
                end else begin
                    nwait_d = 1'b0;
                end
`endif
            end

            RD_DRIVE: begin
                if (oe_s || cs_s) begin
                    state_d = IDLE;
                end else begin
                    d_oe_d = 1'b1;
                end
            end

            WAIT_IDLE: begin
                if (we_s && oe_s && cs_s) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge c0) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // flop samples pre-edge values regardless of statement order.
        if (!nRST) begin
            // NOTE: the synchroniser flops are reset to the idle (high) strobe
            // level so the first cycles after reset cannot look like a fall.
            cs_sync    <= '1;
            we_sync    <= '1;
            oe_sync    <= '1;
            we_prev    <= 1'b1;
            oe_prev    <= 1'b1;
            state      <= IDLE;
            cnt        <= '0;
            reg_wr     <= 1'b0;
            reg_rd     <= 1'b0;
            reg_addr   <= '0;
            reg_wdata  <= '0;
            reg_be     <= '0;
            EMIF_D_out <= '0;
            EMIF_D_oe  <= 1'b0;
            EMIF_nWAIT <= 1'b1;
            proto_err  <= 1'b0;
        end else begin
            cs_sync    <= {cs_sync[SYNC_STAGES-2:0], EMIF_nCS};
            we_sync    <= {we_sync[SYNC_STAGES-2:0], EMIF_nWE};
            oe_sync    <= {oe_sync[SYNC_STAGES-2:0], EMIF_nOE};
            we_prev    <= we_s;
            oe_prev    <= oe_s;
            state      <= state_d;
            cnt        <= cnt_d;
            reg_wr     <= reg_wr_d;
            reg_rd     <= reg_rd_d;
            reg_addr   <= reg_addr_d;
            reg_wdata  <= reg_wdata_d;
            reg_be     <= reg_be_d;
            EMIF_D_out <= d_out_d;
            EMIF_D_oe  <= d_oe_d;
            EMIF_nWAIT <= nwait_d;
            proto_err  <= proto_err_d;
        end
    end

endmodule
